// File: rtl/matrix_pkg.sv
// Shared types for the matrix frame scheduler: one 8-pixel row and an 8x8 frame.
package matrix_pkg;
  typedef logic [7:0] row_t;
  typedef row_t [7:0] frame_t;
  localparam int NREQ = 2;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin row-write arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2
  import matrix_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  input  logic            stall,
  output logic [NREQ-1:0] gnt
);
  logic ptr;

  // Grants are suppressed while in reset so a held request cannot write during it.
  always_comb begin
    gnt = '0;
    if (nrst && !stall) begin
      if (req[0] && (!req[1] || !ptr)) gnt = 2'b01;
      else if (req[1])                 gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)       ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end
endmodule

// File: rtl/matrix_frame_scheduler.sv
// Double-buffered frame scheduler: arbitrated row writes into a back buffer,
// published to the front buffer on request once the current frame has been held long enough.
module matrix_frame_scheduler
  import matrix_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [1:0]      req,
  input  logic [2:0]      row0,
  input  logic [7:0]      data0,
  input  logic [2:0]      row1,
  input  logic [7:0]      data1,
  output logic [1:0]      gnt,
  input  logic            swap_req,
  input  logic            blank,
  output logic            swap_pend,
  output logic [7:0][7:0] matdata,
  output logic            drv_en
);
  localparam int             CW   = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0]  CMAX = CW'(HOLD_CYCLES - 1);

  frame_t        back, front;
  logic [CW-1:0] cnt;
  logic          shown;
  logic          swap;

  // Swap steals the cycle from the writers so a copy never races a row update.
  assign swap = swap_pend && (cnt == CMAX);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .nrst  (nrst),
    .req   (req),
    .stall (swap),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      back      <= '0;
      front     <= '0;
      cnt       <= '0;
      shown     <= 1'b0;
      swap_pend <= 1'b0;
      drv_en    <= 1'b0;
    end else begin
      if (gnt[0])      back[row0] <= data0;
      else if (gnt[1]) back[row1] <= data1;
      if (swap) begin
        front <= back;
        cnt   <= '0;
        shown <= 1'b1;
      end else if (cnt != CMAX) begin
        cnt <= cnt + CW'(1);
      end
      swap_pend <= swap_req | (swap_pend & ~swap);
      drv_en    <= shown & ~blank;
    end
  end

  assign matdata = front;
endmodule
